cnt_event_reporter: RTL and testbench
=====================================

Name: cnt_event_reporter

Overview:
- Sits directly downstream of the N-bit enable-gated event counter and consumes its `cnt` output.
- Samples `cnt` every cycle and classifies each change as wrap-around, non-sequential jump or armed compare match.
- Queues classified events in a small FIFO and delivers them to a host/monitor over a valid/ready interface.
- Gives the monitor side one record per notable counter event instead of polling the raw count.

Parameters:
- N, 7, counter width; must equal the upstream counter's N.
- DEPTH, 4, event FIFO depth (power of two, ≥2).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- cnt  in  N  count value from the upstream counter.
- arm  in  1  level; rising use arms the compare (see FSM).
- cmp_val  in  N  compare value, latched when arming.
- clr_ovf  in  1  pulse, clears the sticky overflow flag.
- evt_valid  out  1  FIFO head is valid.
- evt_ready  in  1  consumer accepts the head this cycle.
- evt_flags  out  3  head flags {match, jump, wrap}.
- evt_cnt  out  N  `cnt` value at the time the event was captured.
- overflow  out  1  sticky: at least one event was dropped.
- armed  out  1  FSM is in ARMED.

Behaviour:
- Reset (rst_n low, asynchronous):
  - cnt_q=0, cmp_q=0, FSM=IDLE, FIFO empty.
  - Outputs: evt_valid=0, evt_flags=0, evt_cnt=0, overflow=0, armed=0.
- Per-edge sampling:
  - cnt_q <= cnt on every clk edge.
  - chg = (cnt != cnt_q).
- Classification, combinational on the current cnt and cnt_q, all widths N, mod 2^N:
  - wrap = chg && cnt_q=={N{1}} && cnt==0.
  - jump = chg && cnt != cnt_q+1 && !wrap. This covers an upstream reset mid-count and skips.
  - match = chg && FSM==ARMED && cnt==cmp_q.
  - A normal +1 step that is not a match produces no event.
  - wrap and jump are mutually exclusive; match may coexist with either in one entry, e.g. cmp_q=0 at a wrap gives flags=3'b101.
- Push rule: push = match|jump|wrap.
  - The entry is {flags, cnt}, written at the same edge where cnt_q updates.
  - evt_valid rises the cycle after the upstream cnt changed (1-cycle latency).
- FSM, with states IDLE, ARMED and DONE:
  - IDLE: arm=1 → latch cmp_q<=cmp_val, go to ARMED.
  - ARMED: match → DONE. arm=0 → IDLE (disarm, no event).
  - DONE: stays until arm=0, then IDLE. This prevents re-firing on the next wrap while arm is held.
  - armed=1 only in ARMED. Changing cmp_val while ARMED has no effect.
- FIFO:
  - First-word-fall-through: evt_valid = !empty, evt_flags/evt_cnt = head.
  - Pop when evt_valid && evt_ready.
  - Full, push and pop in the same cycle → both succeed, occupancy unchanged.
  - Full, push and no pop → entry dropped and overflow<=1. The FSM still advances on a dropped match.
  - Empty and push with evt_ready=1 → no same-cycle bypass; the entry appears next cycle.
  - Outputs are stable while evt_valid=1 && evt_ready=0.
- overflow:
  - Cleared by clr_ovf.
  - clr_ovf and a drop in the same cycle → overflow=1; the drop wins.
- Reset mid-operation: all state and FIFO contents are discarded; no event is generated for the jump seen after reset.

Decomposition:
- Package cnt_evt_pkg:
  - state_t enum {IDLE, ARMED, DONE}.
  - FLAG_W=3.
  - Bit indices FLG_WRAP=0, FLG_JUMP=1, FLG_MATCH=2.
  - Struct evt_t {flags, cnt}, parameterised via N in the module.
- One sub-module: evt_fifo, a generic FWFT FIFO parameterised by width/depth, with push, pop, full, empty.
- The classifier and FSM stay in the top module.

Test Plan:
- Wrap: drive cnt 125,126,127,0 with evt_ready=1 → exactly one entry, flags=3'b001, evt_cnt=0, evt_valid one cycle after cnt=0.
- Match:
  - Step 1: arm=1, cmp_val=10, step cnt 8→9→10→11 → one entry flags=3'b100, evt_cnt=10; FSM goes to DONE.
  - Step 2: wrap around to 10 again with arm still 1 → no new match.
- Jump: cnt 40→0 (upstream reset) → flags=3'b010, evt_cnt=0; cnt 5→9 → flags=3'b010, evt_cnt=9.
- Combined: arm with cmp_val=0, cnt 127→0 → single entry flags=3'b101.
- Backpressure/overflow, with evt_ready=0:
  - Step 1: generate 5 jumps → 4 entries held; overflow=1 after the 5th; head evt_cnt is unchanged throughout.
  - Step 2: pop all four → values in order, no 5th entry.
  - Step 3: clr_ovf → overflow=0.
- Reset mid-stream: with 3 entries queued and FSM in ARMED, pulse rst_n low → evt_valid=0, armed=0, overflow=0 immediately (asynchronous); no event on the next edge.

Source files
------------

// File: rtl/cnt_evt_pkg.sv
// Shared types and constants for the counter event reporter.
//   state_t : compare-arming FSM states
//   FLAG_W  : width of the event flag field
//   FLG_*   : bit positions of each flag within the flag field
package cnt_evt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned FLAG_W    = 3;
  localparam int unsigned FLG_WRAP  = 0;
  localparam int unsigned FLG_JUMP  = 1;
  localparam int unsigned FLG_MATCH = 2;

endpackage

// File: rtl/evt_fifo.sv
// Generic first-word-fall-through FIFO.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push/wdata : write request; accepted when not full, or when full and popping
//   pop        : removes the head when not empty
//   rdata      : current head entry (meaningful only while !empty)
//   full/empty : occupancy status
module evt_fifo #(
  parameter int unsigned W     = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  // Extra MSB distinguishes full from empty when the indices coincide.
  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic         do_push, do_pop;

  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push needs.
    do_push = push && (!full || do_pop);
    rdata   = mem[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/cnt_event_reporter.sv
// Watches an upstream counter value and reports wrap, jump and compare-match
// events as {flags, cnt} records through a FWFT FIFO with valid/ready handshake.
//   cnt              : upstream count, sampled every edge
//   arm, cmp_val     : arm the compare; cmp_val latched on arming
//   clr_ovf          : clears the sticky overflow flag
//   evt_valid/ready  : head-of-queue handshake
//   evt_flags        : {match, jump, wrap} of the head entry
//   evt_cnt          : count value captured with the head entry
//   overflow         : sticky, an event was dropped on a full queue
//   armed            : compare FSM is in ARMED
module cnt_event_reporter
  import cnt_evt_pkg::*;
#(
  parameter int unsigned N     = 7,
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      cnt,
  input  logic              arm,
  input  logic [N-1:0]      cmp_val,
  input  logic              clr_ovf,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [FLAG_W-1:0] evt_flags,
  output logic [N-1:0]      evt_cnt,
  output logic              overflow,
  output logic              armed
);

  typedef struct packed {
    logic [FLAG_W-1:0] flags;
    logic [N-1:0]      cnt;
  } evt_t;

  localparam int unsigned EW = FLAG_W + N;

  state_t      state_q, state_d;
  logic [N-1:0] cnt_q, cmp_q, cmp_d, cnt_inc;
  logic        first_q;
  logic        overflow_q, overflow_d;
  logic        chg, wrap, jump, match, push, drop;
  logic        fifo_full, fifo_empty, pop;
  evt_t        new_evt, head;

  always_comb begin
    cnt_inc = cnt_q + 1'b1;
    chg     = (cnt != cnt_q);
    wrap    = chg && (cnt_q == '1) && (cnt == '0);
    jump    = chg && (cnt != cnt_inc) && !wrap;
    match   = chg && (state_q == ARMED) && (cnt == cmp_q);
    // The first edge after reset compares against the reset value of cnt_q,
    // not a real previous sample, so it must not report anything.
    push    = (match || jump || wrap) && !first_q;

    new_evt                   = '0;
    new_evt.flags[FLG_WRAP]   = wrap;
    new_evt.flags[FLG_JUMP]   = jump;
    new_evt.flags[FLG_MATCH]  = match;
    new_evt.cnt               = cnt;

    evt_valid = !fifo_empty;
    pop       = evt_valid && evt_ready;
    drop      = push && fifo_full && !pop;
    evt_flags = evt_valid ? head.flags : '0;
    evt_cnt   = evt_valid ? head.cnt : '0;
  end

  // Compare FSM: DONE holds until arm drops so a held arm cannot re-fire.
  always_comb begin
    state_d = state_q;
    cmp_d   = cmp_q;
    unique case (state_q)
      IDLE: begin
        if (arm) begin
          cmp_d   = cmp_val;
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (match)     state_d = DONE;
        else if (!arm) state_d = IDLE;
      end
      DONE: begin
        if (!arm) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A drop in the same cycle as clr_ovf keeps the flag set.
  always_comb begin
    overflow_d = overflow_q;
    if (drop)         overflow_d = 1'b1;
    else if (clr_ovf) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      cmp_q      <= '0;
      state_q    <= IDLE;
      first_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      cnt_q      <= cnt;
      cmp_q      <= cmp_d;
      state_q    <= state_d;
      first_q    <= 1'b0;
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;
  assign armed    = (state_q == ARMED);

  evt_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (new_evt),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_cnt_event_reporter.sv
// Self-checking bench for cnt_event_reporter with a queue-based reference model.
module tb_cnt_event_reporter;

  localparam int unsigned N     = 7;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned MOD   = 128;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] cnt, cmp_val;
  logic         arm, clr_ovf, evt_ready;
  logic         evt_valid, overflow, armed;
  logic [2:0]   evt_flags;
  logic [N-1:0] evt_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [9:0]  m_q [$];   // {flags, cnt}
  int unsigned m_prev;
  bit          m_first;
  int          m_mode;    // 0 idle, 1 waiting for match, 2 fired
  int unsigned m_cmp;
  bit          m_ovf;

  cnt_event_reporter #(
    .N     (N),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cnt       (cnt),
    .arm       (arm),
    .cmp_val   (cmp_val),
    .clr_ovf   (clr_ovf),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_flags (evt_flags),
    .evt_cnt   (evt_cnt),
    .overflow  (overflow),
    .armed     (armed)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_q.delete();
    m_prev  = 0;
    m_first = 1'b1;
    m_mode  = 0;
    m_cmp   = 0;
    m_ovf   = 1'b0;
  endtask

  // Apply one cycle of inputs, advance the model, return just after the edge.
  task automatic drive_cycle(input logic [N-1:0] c, input logic a, input logic [N-1:0] cv,
                             input logic clr, input logic rdy);
    bit          chg, wrap, jump, match, do_pop;
    int unsigned cu;
    @(negedge clk);
    cnt = c; arm = a; cmp_val = cv; clr_ovf = clr; evt_ready = rdy;
    cu     = int'(c);
    chg    = (cu != m_prev);
    wrap   = chg && (m_prev == MOD - 1) && (cu == 0);
    jump   = chg && (cu != (m_prev + 1) % MOD) && !wrap;
    match  = chg && (m_mode == 1) && (cu == m_cmp);
    do_pop = (m_q.size() > 0) && rdy;
    if (do_pop) void'(m_q.pop_front());
    if (clr) m_ovf = 1'b0;
    if (!m_first && (wrap || jump || match)) begin
      if (m_q.size() < DEPTH) m_q.push_back({match, jump, wrap, c});
      else m_ovf = 1'b1;
    end
    case (m_mode)
      0: if (a) begin m_cmp = int'(cv); m_mode = 1; end
      1: if (match) m_mode = 2; else if (!a) m_mode = 0;
      default: if (!a) m_mode = 0;
    endcase
    m_prev  = cu;
    m_first = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cnt = '0; arm = 1'b0; cmp_val = '0; clr_ovf = 1'b0; evt_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (evt_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", evt_valid); end
    n_checks++; if (evt_flags !== 3'b000) begin n_errors++; $display("FAIL reset_flags: got %b want 000", evt_flags); end
    n_checks++; if (evt_cnt !== 7'd0) begin n_errors++; $display("FAIL reset_cnt: got %0d want 0", evt_cnt); end
    n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    n_checks++; if (armed !== 1'b0) begin n_errors++; $display("FAIL reset_armed: got %b want 0", armed); end
    rst_n = 1'b1;
  endtask

  task automatic test_wrap();
    drive_cycle(7'd125, 1'b0, 7'd0, 1'b0, 1'b1);
    n_checks++; if (evt_valid !== 1'b0) begin n_errors++; $display("FAIL wrap_first_edge: got %b want 0", evt_valid); end
    drive_cycle(7'd126, 1'b0, 7'd0, 1'b0, 1'b1);
    drive_cycle(7'd127, 1'b0, 7'd0, 1'b0, 1'b1);
    n_checks++; if (evt_valid !== 1'b0) begin n_errors++; $display("FAIL wrap_steps_quiet: got %b want 0", evt_valid); end
    drive_cycle(7'd0, 1'b0, 7'd0, 1'b0, 1'b1);
    n_checks++; if (evt_valid !== 1'b1) begin n_errors++; $display("FAIL wrap_valid: got %b want 1", evt_valid); end
    n_checks++; if (evt_flags !== 3'b001) begin n_errors++; $display("FAIL wrap_flags: got %b want 001", evt_flags); end
    n_checks++; if (evt_cnt !== 7'd0) begin n_errors++; $display("FAIL wrap_cnt: got %0d want 0", evt_cnt); end
    drive_cycle(7'd0, 1'b0, 7'd0, 1'b0, 1'b1);
    n_checks++; if (evt_valid !== 1'b0) begin n_errors++; $display("FAIL wrap_single: got %b want 0", evt_valid); end
  endtask

  task automatic test_match();
    drive_cycle(7'd8, 1'b1, 7'd10, 1'b0, 1'b1);
    n_checks++; if (armed !== 1'b1) begin n_errors++; $display("FAIL match_armed: got %b want 1", armed); end
    drive_cycle(7'd9, 1'b1, 7'd50, 1'b0, 1'b1);  // cmp_val change ignored while armed
    drive_cycle(7'd10, 1'b1, 7'd50, 1'b0, 1'b1);
    n_checks++; if (evt_valid !== 1'b1) begin n_errors++; $display("FAIL match_valid: got %b want 1", evt_valid); end
    n_checks++; if (evt_flags !== 3'b100) begin n_errors++; $display("FAIL match_flags: got %b want 100", evt_flags); end
    n_checks++; if (evt_cnt !== 7'd10) begin n_errors++; $display("FAIL match_cnt: got %0d want 10", evt_cnt); end
    n_checks++; if (armed !== 1'b0) begin n_errors++; $display("FAIL match_done: got %b want 0", armed); end
    drive_cycle(7'd11, 1'b1, 7'd10, 1'b0, 1'b1);
    drive_cycle(7'd127, 1'b1, 7'd10, 1'b0, 1'b1);
    drive_cycle(7'd0, 1'b1, 7'd10, 1'b0, 1'b1);
    drive_cycle(7'd9, 1'b1, 7'd10, 1'b0, 1'b1);
    drive_cycle(7'd10, 1'b1, 7'd10, 1'b0, 1'b1);
    n_checks++; if (evt_valid !== 1'b0) begin n_errors++; $display("FAIL match_no_refire: got %b want 0", evt_valid); end
    drive_cycle(7'd10, 1'b0, 7'd10, 1'b0, 1'b1);
    n_checks++; if (armed !== 1'b0) begin n_errors++; $display("FAIL match_disarm: got %b want 0", armed); end
  endtask

  task automatic test_jump();
    drive_cycle(7'd40, 1'b0, 7'd0, 1'b0, 1'b1);
    drive_cycle(7'd40, 1'b0, 7'd0, 1'b0, 1'b1);
    drive_cycle(7'd0, 1'b0, 7'd0, 1'b0, 1'b0);
    n_checks++; if (evt_flags !== 3'b010) begin n_errors++; $display("FAIL jump0_flags: got %b want 010", evt_flags); end
    n_checks++; if (evt_cnt !== 7'd0) begin n_errors++; $display("FAIL jump0_cnt: got %0d want 0", evt_cnt); end
    drive_cycle(7'd0, 1'b0, 7'd0, 1'b0, 1'b1);
    drive_cycle(7'd5, 1'b0, 7'd0, 1'b0, 1'b1);
    drive_cycle(7'd5, 1'b0, 7'd0, 1'b0, 1'b1);
    drive_cycle(7'd9, 1'b0, 7'd0, 1'b0, 1'b0);
    n_checks++; if (evt_flags !== 3'b010) begin n_errors++; $display("FAIL jump9_flags: got %b want 010", evt_flags); end
    n_checks++; if (evt_cnt !== 7'd9) begin n_errors++; $display("FAIL jump9_cnt: got %0d want 9", evt_cnt); end
    drive_cycle(7'd9, 1'b0, 7'd0, 1'b0, 1'b1);
  endtask

  task automatic test_combined();
    drive_cycle(7'd127, 1'b1, 7'd0, 1'b0, 1'b1);
    drive_cycle(7'd127, 1'b1, 7'd0, 1'b0, 1'b1);
    drive_cycle(7'd0, 1'b1, 7'd0, 1'b0, 1'b0);
    n_checks++; if (evt_flags !== 3'b101) begin n_errors++; $display("FAIL combined_flags: got %b want 101", evt_flags); end
    n_checks++; if (evt_cnt !== 7'd0) begin n_errors++; $display("FAIL combined_cnt: got %0d want 0", evt_cnt); end
    drive_cycle(7'd0, 1'b0, 7'd0, 1'b0, 1'b1);
    n_checks++; if (evt_valid !== 1'b0) begin n_errors++; $display("FAIL combined_single: got %b want 0", evt_valid); end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] vals [5];
    vals = '{7'd20, 7'd30, 7'd40, 7'd50, 7'd60};
    for (int i = 0; i < 5; i++) begin
      drive_cycle(vals[i], 1'b0, 7'd0, 1'b0, 1'b0);
      n_checks++; if (evt_cnt !== 7'd20) begin n_errors++; $display("FAIL bp_head%0d: got %0d want 20", i, evt_cnt); end
      n_checks++; if (overflow !== (i == 4)) begin n_errors++; $display("FAIL bp_ovf%0d: got %b want %b", i, overflow, (i == 4)); end
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (evt_cnt !== vals[i]) begin n_errors++; $display("FAIL bp_order%0d: got %0d want %0d", i, evt_cnt, vals[i]); end
      drive_cycle(7'd60, 1'b0, 7'd0, 1'b0, 1'b1);
    end
    n_checks++; if (evt_valid !== 1'b0) begin n_errors++; $display("FAIL bp_drained: got %b want 0", evt_valid); end
    drive_cycle(7'd60, 1'b0, 7'd0, 1'b1, 1'b1);
    n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL bp_clr: got %b want 0", overflow); end
  endtask

  task automatic test_reset_mid();
    drive_cycle(7'd70, 1'b1, 7'd100, 1'b0, 1'b0);
    drive_cycle(7'd80, 1'b1, 7'd100, 1'b0, 1'b0);
    drive_cycle(7'd90, 1'b1, 7'd100, 1'b0, 1'b0);
    n_checks++; if (armed !== 1'b1 || evt_valid !== 1'b1) begin n_errors++; $display("FAIL rmid_pre: got armed=%b valid=%b want 1 1", armed, evt_valid); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (evt_valid !== 1'b0) begin n_errors++; $display("FAIL rmid_valid: got %b want 0", evt_valid); end
    n_checks++; if (armed !== 1'b0) begin n_errors++; $display("FAIL rmid_armed: got %b want 0", armed); end
    n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL rmid_ovf: got %b want 0", overflow); end
    #1 rst_n = 1'b1;
    model_reset();
    drive_cycle(7'd90, 1'b0, 7'd0, 1'b0, 1'b0);
    n_checks++; if (evt_valid !== 1'b0) begin n_errors++; $display("FAIL rmid_no_evt: got %b want 0", evt_valid); end
  endtask

  task automatic test_random();
    logic [N-1:0] c, cv;
    logic         a;
    logic [2:0]   ef;
    logic [N-1:0] ec;
    c = cnt; a = 1'b0; cv = 7'd0;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: c = c + 1'b1;
        6: c = c;
        7: c = 7'($urandom_range(0, 127));
        8: c = 7'd127;
        default: c = cv;
      endcase
      if ($urandom_range(0, 7) == 0) a = ~a;
      if ($urandom_range(0, 3) == 0) cv = 7'($urandom_range(0, 127));
      drive_cycle(c, a, cv, ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) != 0));
      ef = (m_q.size() > 0) ? m_q[0][9:7] : 3'b000;
      ec = (m_q.size() > 0) ? m_q[0][6:0] : 7'd0;
      n_checks++; if (evt_valid !== (m_q.size() > 0)) begin n_errors++; $display("FAIL rnd_valid@%0d: got %b want %b", i, evt_valid, (m_q.size() > 0)); end
      n_checks++; if (evt_flags !== ef) begin n_errors++; $display("FAIL rnd_flags@%0d: got %b want %b", i, evt_flags, ef); end
      n_checks++; if (evt_cnt !== ec) begin n_errors++; $display("FAIL rnd_cnt@%0d: got %0d want %0d", i, evt_cnt, ec); end
      n_checks++; if (overflow !== m_ovf) begin n_errors++; $display("FAIL rnd_ovf@%0d: got %b want %b", i, overflow, m_ovf); end
      n_checks++; if (armed !== (m_mode == 1)) begin n_errors++; $display("FAIL rnd_armed@%0d: got %b want %b", i, armed, (m_mode == 1)); end
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_match();
    test_jump();
    test_combined();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
